midi_note_rx: RTL and testbench

MIDI_NOTE_RX -- requirements
Module: midi_note_rx

---
 rtl/midi_note_rx.sv | 204 ++++++++++++++++++++
 tb/tb_midi_note_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_rx.sv
// MIDI serial receiver and monophonic note tracker: 8N1 UART front end, running-status
// parser, last-note-priority gate/note/velocity/amp outputs. Define MIDI_OMNI_EN for omni mode.
module midi_note_rx #(
    parameter int unsigned CLKSPEED = 48_000_000,
    parameter int unsigned BAUD     = 31_250,
    parameter int unsigned CHANNEL  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [9:0] amp,
    output logic       note_strobe,
    output logic       frame_err
);

    localparam int unsigned Div  = CLKSPEED / BAUD;
    localparam int unsigned Half = Div / 2;
    localparam int unsigned CntW = $clog2(Div + 1);
    localparam logic [CntW-1:0] BitEnd  = CntW'(Div - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(Half - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic            sync1_q, sync2_q, rx_prev_q, rx;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid, frame_err_set;

    logic [7:0] status_q, status_d;
    logic       data_cnt_q, data_cnt_d;
    logic [6:0] key_q, key_d;
    logic       gate_q, gate_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic       strobe_q, strobe_d;
    logic [9:0] amp_q, amp_d;
    logic       frame_err_q;
    logic       two_byte, is_note, ch_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= midi_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (rx_prev_q && !rx) state_d = StStart;
            StStart: if (cnt_q == HalfEnd) state_d = rx ? StIdle : StData;
            StData:  if (cnt_q == BitEnd && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (cnt_q == BitEnd) state_d = rx ? StIdle : StBreak;
            // After a framing error, wait for a full bit time of idle line before rearming.
            StBreak: if (rx && cnt_q == BitEnd) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_valid    = 1'b0;
        frame_err_set = 1'b0;
        if (state_q == StStop && cnt_q == BitEnd) begin
            byte_valid    = rx;
            frame_err_set = !rx;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            StIdle: cnt_d = '0;
            StStart: begin
                bit_idx_d = '0;
                if (cnt_q == HalfEnd) cnt_d = '0;
            end
            StData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d     = '0;
                    shift_d   = {rx, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop:  if (cnt_q == BitEnd) cnt_d = '0;
            StBreak: if (!rx || cnt_q == BitEnd) cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    assign two_byte = (status_q[6:4] != 3'b100) && (status_q[6:4] != 3'b101);
    assign is_note  = (status_q[6:5] == 2'b00);
`ifdef MIDI_OMNI_EN
    assign ch_ok = 1'b1;
`else
    localparam logic [3:0] ChanSel = 4'(CHANNEL);
    assign ch_ok = (status_q[3:0] == ChanSel);
`endif

    // status_q[7] doubles as the running-status valid flag.
    always_comb begin
        status_d   = status_q;
        data_cnt_d = data_cnt_q;
        key_d      = key_q;
        gate_d     = gate_q;
        note_d     = note_q;
        vel_d      = vel_q;
        strobe_d   = 1'b0;
        if (byte_valid && shift_q < 8'hF8) begin
            if (shift_q >= 8'hF0) begin
                status_d   = '0;
                data_cnt_d = 1'b0;
            end else if (shift_q[7]) begin
                status_d   = shift_q;
                data_cnt_d = 1'b0;
            end else if (status_q[7]) begin
                if (!data_cnt_q && two_byte) begin
                    key_d      = shift_q[6:0];
                    data_cnt_d = 1'b1;
                end else begin
                    data_cnt_d = 1'b0;
                    if (is_note && ch_ok) begin
                        if (status_q[4] && shift_q[6:0] != 7'd0) begin
                            gate_d   = 1'b1;
                            note_d   = key_q;
                            vel_d    = shift_q[6:0];
                            strobe_d = 1'b1;
                        end else if (gate_q && key_q == note_q) begin
                            gate_d   = 1'b0;
                            strobe_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign amp_d = gate_q ? {vel_q, 3'b111} : 10'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q    <= '0;
            data_cnt_q  <= 1'b0;
            key_q       <= '0;
            gate_q      <= 1'b0;
            note_q      <= '0;
            vel_q       <= '0;
            strobe_q    <= 1'b0;
            amp_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            status_q    <= status_d;
            data_cnt_q  <= data_cnt_d;
            key_q       <= key_d;
            gate_q      <= gate_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            strobe_q    <= strobe_d;
            amp_q       <= amp_d;
            frame_err_q <= frame_err_set;
        end
    end

    assign gate        = gate_q;
    assign note        = note_q;
    assign velocity    = vel_q;
    assign amp         = amp_q;
    assign note_strobe = strobe_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// Self-checking bench for midi_note_rx: table of MIDI messages with expected note state,
// plus a note_strobe scoreboard and hand-written framing-error / reset sequences.
module tb_midi_note_rx;

    localparam int Div = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_in = 1'b1;
    logic       gate;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [9:0] amp;
    logic       note_strobe;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int fe_count = 0;

    typedef struct {
        logic       g;
        logic [6:0] n;
        logic [6:0] v;
    } ev_t;

    typedef struct {
        string           name;
        int              n;
        logic [4:0][7:0] bytes;
        int              strobes;
        logic            g;
        logic [6:0]      nt;
        logic [6:0]      vl;
        logic [9:0]      am;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[$];

    midi_note_rx #(
        .CLKSPEED(500_000),
        .BAUD    (31_250),
        .CHANNEL (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .midi_in    (midi_in),
        .gate       (gate),
        .note       (note),
        .velocity   (velocity),
        .amp        (amp),
        .note_strobe(note_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4, input int s,
                                input logic g, input logic [6:0] nt, input logic [6:0] vl,
                                input logic [9:0] am);
        vec_t v;
        v.name    = nm;
        v.n       = n;
        v.bytes   = {b4, b3, b2, b1, b0};
        v.strobes = s;
        v.g       = g;
        v.nt      = nt;
        v.vl      = vl;
        v.am      = am;
        return v;
    endfunction

    // Scoreboard: every note_strobe consumes one expected event.
    ev_t ev;
    always @(negedge clk) begin
        if (rst_n && note_strobe) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe gate=%0d note=%0h expected none",
                         gate, note);
            end else begin
                ev = sb.pop_front();
                chk("strobe_gate", 32'(gate), 32'(ev.g));
                chk("strobe_note", 32'(note), 32'(ev.n));
                chk("strobe_vel", 32'(velocity), 32'(ev.v));
            end
        end
        if (rst_n && frame_err) fe_count++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits);
        @(negedge clk);
        midi_in = 1'b0;
        repeat (Div) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            midi_in = b[i];
            repeat (Div) @(negedge clk);
        end
        if (nbits == 8) begin
            midi_in = stop_bit;
            repeat (Div) @(negedge clk);
            midi_in = 1'b1;
            repeat (3 * Div) @(negedge clk);
        end
    endtask

    task automatic chk_state(input string nm, input logic g, input logic [6:0] nt,
                             input logic [6:0] vl, input logic [9:0] am);
        chk({nm, ".pending"}, 32'(sb.size()), 32'd0);
        chk({nm, ".gate"}, 32'(gate), 32'(g));
        chk({nm, ".note"}, 32'(note), 32'(nt));
        chk({nm, ".vel"}, 32'(velocity), 32'(vl));
        chk({nm, ".amp"}, 32'(amp), 32'(am));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".gate"}, 32'(gate), 32'd0);
        chk({nm, ".note"}, 32'(note), 32'd0);
        chk({nm, ".vel"}, 32'(velocity), 32'd0);
        chk({nm, ".amp"}, 32'(amp), 32'd0);
        chk({nm, ".strobe"}, 32'(note_strobe), 32'd0);
        chk({nm, ".frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int fe_before;
        ev_t e;

        vecs.push_back(mk("on", 3, 8'h90, 8'h3C, 8'h64, 0, 0, 1, 1, 7'h3C, 7'h64, 10'h327));
        vecs.push_back(mk("rs_off", 2, 8'h3C, 8'h00, 0, 0, 0, 1, 0, 7'h3C, 7'h64, 10'h000));
        vecs.push_back(mk("on2", 3, 8'h90, 8'h3C, 8'h64, 0, 0, 1, 1, 7'h3C, 7'h64, 10'h327));
        vecs.push_back(mk("last", 3, 8'h90, 8'h40, 8'h7F, 0, 0, 1, 1, 7'h40, 7'h7F, 10'h3FF));
        vecs.push_back(mk("off_old", 3, 8'h80, 8'h3C, 8'h40, 0, 0, 0, 1, 7'h40, 7'h7F, 10'h3FF));
        vecs.push_back(mk("off_cur", 3, 8'h80, 8'h40, 8'h00, 0, 0, 1, 0, 7'h40, 7'h7F, 10'h000));
        vecs.push_back(mk("rt_mix", 5, 8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 1, 1, 7'h3C, 7'h64,
                          10'h327));
        vecs.push_back(mk("sysex", 3, 8'hF0, 8'h3C, 8'h64, 0, 0, 0, 1, 7'h3C, 7'h64, 10'h327));
        vecs.push_back(mk("no_rs", 2, 8'h3C, 8'h00, 0, 0, 0, 0, 1, 7'h3C, 7'h64, 10'h327));
        vecs.push_back(mk("off3", 3, 8'h80, 8'h3C, 8'h00, 0, 0, 1, 0, 7'h3C, 7'h64, 10'h000));
`ifdef MIDI_OMNI_EN
        vecs.push_back(mk("ch1", 3, 8'h91, 8'h3C, 8'h64, 0, 0, 1, 1, 7'h3C, 7'h64, 10'h327));
`else
        vecs.push_back(mk("ch1", 3, 8'h91, 8'h3C, 8'h64, 0, 0, 0, 0, 7'h3C, 7'h64, 10'h000));
`endif
        vecs.push_back(mk("pc_then_on", 5, 8'hC0, 8'h05, 8'h90, 8'h45, 8'h50, 1, 1, 7'h45, 7'h50,
                          10'h287));
        vecs.push_back(mk("vel0_off", 3, 8'h90, 8'h45, 8'h00, 0, 0, 1, 0, 7'h45, 7'h50, 10'h000));
        vecs.push_back(mk("off_idle", 3, 8'h90, 8'h46, 8'h00, 0, 0, 0, 0, 7'h45, 7'h50, 10'h000));

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2 * Div) @(negedge clk);

        foreach (vecs[k]) begin
            if (vecs[k].strobes == 1) begin
                e.g = vecs[k].g;
                e.n = vecs[k].nt;
                e.v = vecs[k].vl;
                sb.push_back(e);
            end
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].bytes[i], 1'b1, 8);
            chk_state(vecs[k].name, vecs[k].g, vecs[k].nt, vecs[k].vl, vecs[k].am);
        end

        // Short low glitch must be rejected at the start-bit check.
        @(negedge clk);
        midi_in = 1'b0;
        repeat (3) @(negedge clk);
        midi_in = 1'b1;
        repeat (3 * Div) @(negedge clk);
        chk("glitch_fe", 32'(fe_count), 32'd0);
        chk_state("glitch", 1'b0, 7'h45, 7'h50, 10'h000);

        fe_before = fe_count;
        send_byte(8'h90, 1'b0, 8);
        chk("bad_stop_fe", 32'(fe_count - fe_before), 32'd1);
        chk_state("bad_stop", 1'b0, 7'h45, 7'h50, 10'h000);

        // Reset in the middle of a status byte.
        send_byte(8'h90, 1'b1, 4);
        rst_n   = 1'b0;
        midi_in = 1'b1;
        repeat (4) @(negedge clk);
        chk_zero("mid_reset");
        rst_n = 1'b1;
        repeat (2 * Div) @(negedge clk);

        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'h64, 1'b1, 8);
        chk_state("post_rst_data", 1'b0, 7'h00, 7'h00, 10'h000);

        e.g = 1'b1;
        e.n = 7'h3C;
        e.v = 7'h64;
        sb.push_back(e);
        send_byte(8'h90, 1'b1, 8);
        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'h64, 1'b1, 8);
        chk_state("post_rst_on", 1'b1, 7'h3C, 7'h64, 10'h327);
        chk("total_fe", 32'(fe_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
